// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: owns the PLL reset and re-lock retry policy, proves
// lock stable, then releases the per-domain resets in a fixed staged order.
// Lock losses seen after release has started are counted for debug.
// Everything runs on the PLL reference clock, never on a PLL output.
module pll_lock_supervisor #(
    parameter int NUM_DOMAINS        = 3,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY        = 16,
    parameter int RELOCK_TIMEOUT     = 65536,
    parameter int PLLRST_PULSE       = 8,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                   clkin,
    input  logic                   resetn,
    input  logic                   pll_locked_in,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_resetn,
    output logic                   locked,
    output logic [LOSS_CNT_W-1:0]  loss_count,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    // One shared counter serves every state, so it is sized for the largest
    // terminal value any state needs.
    localparam int MAX_AB  = (PLLRST_PULSE > RELOCK_TIMEOUT) ? PLLRST_PULSE : RELOCK_TIMEOUT;
    localparam int MAX_CD  = (LOCK_STABLE_CYCLES > STAGE_DELAY) ? LOCK_STABLE_CYCLES : STAGE_DELAY;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] C_PULSE_LAST   = CNT_W'(PLLRST_PULSE - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(RELOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_STAGE_LAST   = CNT_W'(STAGE_DELAY - 1);

    logic [1:0]             r_rst_sync;
    logic [1:0]             r_lock_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_pll_rst;
    logic [NUM_DOMAINS-1:0] r_dom;
    logic                   r_locked;
    logic [LOSS_CNT_W-1:0]  r_loss;

    logic                   w_rst_n;
    logic                   w_lock_s;
    logic [NUM_DOMAINS-1:0] w_dom_first;
    logic [NUM_DOMAINS-1:0] w_dom_shift;

    // Reset bridge: assertion passes straight through, release waits two edges.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Two-flop synchroniser for the asynchronous raw PLL lock.
    always_ff @(posedge clkin or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_lock_sync <= 2'b00;
        end else begin
            r_lock_sync <= {r_lock_sync[0], pll_locked_in};
        end
    end

    assign w_lock_s    = r_lock_sync[1];
    // Domain 0 alone, and the released set grown by one more domain.
    assign w_dom_first = NUM_DOMAINS'(1);
    assign w_dom_shift = (r_dom << 1) | NUM_DOMAINS'(1);

    // Supervisor FSM with all outputs registered.
    always_ff @(posedge clkin or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= ST_RESET_PLL;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            r_dom     <= '0;
            r_locked  <= 1'b0;
            r_loss    <= '0;
        end else begin
            case (r_state)
                ST_RESET_PLL: begin
                    // Lock is meaningless while the PLL is held in reset.
                    r_pll_rst <= 1'b1;
                    r_dom     <= '0;
                    r_locked  <= 1'b0;
                    if (r_cnt == C_PULSE_LAST) begin
                        r_state   <= ST_WAIT_LOCK;
                        r_pll_rst <= 1'b0;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock seen on the timeout cycle still counts as lock.
                    if (w_lock_s) begin
                        if (LOCK_STABLE_CYCLES == 1) begin
                            r_dom <= w_dom_first;
                            r_cnt <= '0;
                            if (NUM_DOMAINS == 1) begin
                                r_locked <= 1'b1;
                                r_state  <= ST_RUN;
                            end else begin
                                r_state <= ST_RELEASE;
                            end
                        end else begin
                            r_state <= ST_STABLE;
                            r_cnt   <= CNT_W'(1);
                        end
                    end else if (r_cnt == C_TIMEOUT_LAST) begin
                        r_state   <= ST_RESET_PLL;
                        r_pll_rst <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    // r_cnt holds the good cycles seen so far; this one makes +1.
                    if (!w_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_STABLE_LAST) begin
                        r_dom <= w_dom_first;
                        r_cnt <= '0;
                        if (NUM_DOMAINS == 1) begin
                            r_locked <= 1'b1;
                            r_state  <= ST_RUN;
                        end else begin
                            r_state <= ST_RELEASE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // Loss is checked first so it beats a release due this cycle.
                    if (!w_lock_s) begin
                        r_state  <= ST_WAIT_LOCK;
                        r_cnt    <= '0;
                        r_dom    <= '0;
                        r_locked <= 1'b0;
                        if (r_loss != '1) begin
                            r_loss <= r_loss + LOSS_CNT_W'(1);
                        end
                    end else if (r_cnt == C_STAGE_LAST) begin
                        r_cnt <= '0;
                        r_dom <= w_dom_shift;
                        if (w_dom_shift[NUM_DOMAINS-1]) begin
                            r_locked <= 1'b1;
                            r_state  <= ST_RUN;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!w_lock_s) begin
                        r_state  <= ST_WAIT_LOCK;
                        r_cnt    <= '0;
                        r_dom    <= '0;
                        r_locked <= 1'b0;
                        if (r_loss != '1) begin
                            r_loss <= r_loss + LOSS_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state   <= ST_RESET_PLL;
                    r_cnt     <= '0;
                    r_pll_rst <= 1'b1;
                    r_dom     <= '0;
                    r_locked  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
        assign domain_resetn[gi] = r_dom[gi];
    end

    assign pll_rst    = r_pll_rst;
    assign locked     = r_locked;
    assign loss_count = r_loss;
    assign state_dbg  = r_state;

endmodule
